// File: rtl/attn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// attn_pkg : shared state encoding and width helpers for the attention step
// sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
package attn_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PROJ  = 4'd1,
    ST_KV_WR = 4'd2,
    ST_KV_RD = 4'd3,
    ST_QK    = 4'd4,
    ST_SM    = 4'd5,
    ST_AV    = 4'd6,
    ST_OUT   = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

  // Slot address width (kept at least 1 bit for a degenerate depth of 1)
  function automatic int aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Length width: must be able to represent the full depth itself
  function automatic int lw(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int hw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/attn_kv_ring_ptr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// attn_kv_ring_ptr : KV ring-buffer write pointer, fill level and sliding
// read-window (base/len) registers.  Rev 1.0
// ----------------------------------------------------------------------------
module attn_kv_ring_ptr import attn_pkg::*; #(
  parameter int SEQ_LEN = 2048,
  parameter int WINDOW  = 2048
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     advance,
  output logic [aw(SEQ_LEN)-1:0]   wr_ptr,
  output logic [aw(SEQ_LEN)-1:0]   rd_base,
  output logic [lw(SEQ_LEN)-1:0]   rd_len
);

  localparam int AW = aw(SEQ_LEN);
  localparam int LW = lw(SEQ_LEN);
  localparam logic [AW-1:0] LAST_SLOT = AW'(SEQ_LEN - 1);
  localparam logic [LW-1:0] DEPTH     = LW'(SEQ_LEN);
  localparam logic [LW-1:0] WIN       = LW'(WINDOW);

  logic [LW-1:0] fill;
  logic [LW-1:0] fill_nx;
  logic [LW-1:0] len_nx;
  logic [AW-1:0] ptr_nx;
  logic [LW:0]   base_sum;
  logic [LW:0]   base_wrap;

  // The window ends at the slot just written, so base = ptr_new - len (mod depth),
  // done with an explicit wrap to stay correct for non-power-of-two depths.
  always_comb begin
    ptr_nx    = (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + AW'(1);
    fill_nx   = (fill == DEPTH) ? fill : fill + LW'(1);
    len_nx    = (fill_nx > WIN) ? WIN : fill_nx;
    base_sum  = {{(LW + 1 - AW){1'b0}}, ptr_nx} + {1'b0, DEPTH} - {1'b0, len_nx};
    base_wrap = (base_sum >= {1'b0, DEPTH}) ? base_sum - {1'b0, DEPTH} : base_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      fill    <= '0;
      rd_base <= '0;
      rd_len  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (advance) begin
      wr_ptr  <= ptr_nx;
      fill    <= fill_nx;
      rd_base <= base_wrap[AW-1:0];
      rd_len  <= len_nx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/attn_step_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// attn_step_seq : one-decode-step multi-head attention sequencer (start/done
// handshakes only). Optional stage watchdog: ATTN_STAGE_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module attn_step_seq import attn_pkg::*; #(
  parameter int SEQ_LEN = 2048,
  parameter int WINDOW  = 2048,
  parameter int HEADS   = 12,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear_ctx,
  output logic                   busy,
  output logic                   step_done,
  output logic                   proj_start,
  input  logic                   proj_done,
  output logic                   kv_we,
  output logic [aw(SEQ_LEN)-1:0] kv_waddr,
  output logic                   kv_rd_start,
  input  logic                   kv_rd_done,
  output logic [aw(SEQ_LEN)-1:0] kv_rd_base,
  output logic [lw(SEQ_LEN)-1:0] kv_rd_len,
  output logic                   qk_start,
  input  logic                   qk_done,
  output logic                   sm_start,
  input  logic                   sm_done,
  output logic                   av_start,
  input  logic                   av_done,
  output logic [hw(HEADS)-1:0]   head_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err
);

  localparam int HW = hw(HEADS);
  localparam logic [HW-1:0] LAST_HEAD = HW'(HEADS - 1);

  state_t          state;
  state_t          state_nx;
  logic [HW-1:0]   head_nx;
  logic            ring_clear;
  logic            ring_adv;
  logic [aw(SEQ_LEN)-1:0] wr_ptr;

  attn_kv_ring_ptr #(
    .SEQ_LEN (SEQ_LEN),
    .WINDOW  (WINDOW)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ring_clear),
    .advance (ring_adv),
    .wr_ptr  (wr_ptr),
    .rd_base (kv_rd_base),
    .rd_len  (kv_rd_len)
  );

`ifdef ATTN_STAGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic          timed;
  logic          tmo_hit;

  assign timed   = (state == ST_PROJ) || (state == ST_KV_RD) || (state == ST_QK) ||
                   (state == ST_SM)   || (state == ST_AV);
  assign tmo_hit = timed && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      tmo_cnt <= (!timed || (state_nx != state)) ? '0 : tmo_cnt + TW'(1);
      // Timed stages never leave to IDLE on their own, so this marks an abort
      if ((state == ST_IDLE) && start)
        err <= 1'b0;
      else if (tmo_hit && (state_nx == ST_IDLE))
        err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // A done coinciding with its own start pulse belongs to an earlier request
  always_comb begin
    state_nx   = state;
    head_nx    = head_idx;
    ring_clear = 1'b0;
    ring_adv   = 1'b0;
    case (state)
      ST_IDLE: begin
        ring_clear = clear_ctx;
        if (start) state_nx = ST_PROJ;
      end
      ST_PROJ:  if (proj_done && !proj_start)   state_nx = ST_KV_WR;
      ST_KV_WR: begin
        ring_adv = 1'b1;
        head_nx  = '0;
        state_nx = ST_KV_RD;
      end
      ST_KV_RD: if (kv_rd_done && !kv_rd_start) state_nx = ST_QK;
      ST_QK:    if (qk_done && !qk_start)       state_nx = ST_SM;
      ST_SM:    if (sm_done && !sm_start)       state_nx = ST_AV;
      ST_AV:    if (av_done && !av_start)       state_nx = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          if (head_idx < LAST_HEAD) begin
            head_nx  = head_idx + HW'(1);
            state_nx = ST_KV_RD;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        head_nx  = '0;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
`ifdef ATTN_STAGE_TIMEOUT_EN
    if (tmo_hit && (state_nx == state)) state_nx = ST_IDLE;
`endif
  end

  // Outputs are registered from the next state so they align with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      step_done   <= 1'b0;
      proj_start  <= 1'b0;
      kv_we       <= 1'b0;
      kv_waddr    <= '0;
      kv_rd_start <= 1'b0;
      qk_start    <= 1'b0;
      sm_start    <= 1'b0;
      av_start    <= 1'b0;
      head_idx    <= '0;
      out_valid   <= 1'b0;
    end else begin
      busy        <= (state_nx != ST_IDLE);
      step_done   <= (state_nx == ST_DONE);
      proj_start  <= (state_nx != state) && (state_nx == ST_PROJ);
      kv_we       <= (state_nx == ST_KV_WR);
      kv_waddr    <= (state_nx == ST_KV_WR) ? wr_ptr : '0;
      kv_rd_start <= (state_nx != state) && (state_nx == ST_KV_RD);
      qk_start    <= (state_nx != state) && (state_nx == ST_QK);
      sm_start    <= (state_nx != state) && (state_nx == ST_SM);
      av_start    <= (state_nx != state) && (state_nx == ST_AV);
      head_idx    <= head_nx;
      out_valid   <= (state_nx == ST_OUT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_attn_step_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_attn_step_seq : scoreboard bench for attn_step_seq (SEQ_LEN=8, WINDOW=4,
// HEADS=2) with randomized done latencies and output backpressure.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_attn_step_seq;

  localparam int SEQ = 8;
  localparam int WIN = 4;
  localparam int NH  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clear_ctx;
  logic       out_ready;
  logic [4:0] dn;
  wire        busy, step_done, proj_start, kv_we, kv_rd_start;
  wire        qk_start, sm_start, av_start, out_valid, err;
  wire  [2:0] kv_waddr;
  wire  [2:0] kv_rd_base;
  wire  [3:0] kv_rd_len;
  wire  [0:0] head_idx;
  logic [31:0] outs;

  always #5 clk = ~clk;

  attn_step_seq #(.SEQ_LEN(SEQ), .WINDOW(WIN), .HEADS(NH), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_ctx(clear_ctx),
    .busy(busy), .step_done(step_done),
    .proj_start(proj_start), .proj_done(dn[0]),
    .kv_we(kv_we), .kv_waddr(kv_waddr),
    .kv_rd_start(kv_rd_start), .kv_rd_done(dn[1]),
    .kv_rd_base(kv_rd_base), .kv_rd_len(kv_rd_len),
    .qk_start(qk_start), .qk_done(dn[2]),
    .sm_start(sm_start), .sm_done(dn[3]),
    .av_start(av_start), .av_done(dn[4]),
    .head_idx(head_idx), .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  assign outs = 32'({busy, step_done, proj_start, kv_we, kv_waddr, kv_rd_start, kv_rd_base,
                     kv_rd_len, qk_start, sm_start, av_start, head_idx, out_valid, err});

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the n-th write since the last clear goes to slot n mod SEQ,
  // and the window covers the newest min(n+1, SEQ, WIN) entries ending there.
  typedef struct { int head; int base; int len; } out_t;
  out_t exp_out[$];
  int   exp_wr[$];
  int   n_since_clear = 0;
  int   exp_steps = 0;
  int   steps_seen = 0;

  task automatic model_issue(input bit clr);
    int len, base;
    out_t o;
    if (clr) n_since_clear = 0;
    len = n_since_clear + 1;
    if (len > SEQ) len = SEQ;
    if (len > WIN) len = WIN;
    base = (n_since_clear + 1 - len) % SEQ;
    exp_wr.push_back(n_since_clear % SEQ);
    for (int h = 0; h < NH; h++) begin
      o.head = h; o.base = base; o.len = len;
      exp_out.push_back(o);
    end
    n_since_clear++;
    exp_steps++;
  endtask

  // Datapath stand-in: one done pulse d cycles after each start pulse
  bit fixed_lat = 1'b1;
  bit spur_en   = 1'b0;
  int cnt [5];
  logic [4:0] st;
  assign st = {av_start, sm_start, qk_start, kv_rd_start, proj_start};

  initial begin
    dn = '0;
    for (int k = 0; k < 5; k++) cnt[k] = 0;
    forever begin
      @(negedge clk);
      dn = '0;
      if (!rst_n) begin
        for (int k = 0; k < 5; k++) cnt[k] = 0;
      end else begin
        for (int k = 0; k < 5; k++) begin
          if (cnt[k] > 0) begin
            cnt[k]--;
            if (cnt[k] == 0) dn[k] = 1'b1;
          end
          if (st[k]) cnt[k] = fixed_lat ? 1 : int'($urandom_range(1, 3));
        end
        if (spur_en && out_valid) dn[2] = 1'b1;
      end
    end
  end

  // Downstream acceptor: 0 = always ready, 1 = random, 2 = stall first result
  int ready_mode = 0;
  int stall_left = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard
  bit held = 1'b0;
  int ph, pb, pl;
  initial begin
    out_t e;
    int w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      if (kv_we) begin
        if (exp_wr.size() == 0) check("unexpected_kv_we", 1, 0);
        else begin
          w = exp_wr.pop_front();
          check("kv_waddr", int'(kv_waddr), w);
        end
      end
      if (held) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_head", int'(head_idx), ph);
        check("hold_base", int'(kv_rd_base), pb);
        check("hold_len", int'(kv_rd_len), pl);
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = exp_out.pop_front();
          check("head_idx", int'(head_idx), e.head);
          check("kv_rd_base", int'(kv_rd_base), e.base);
          check("kv_rd_len", int'(kv_rd_len), e.len);
        end
      end
      held = out_valid && !out_ready;
      ph = int'(head_idx); pb = int'(kv_rd_base); pl = int'(kv_rd_len);
      if (step_done) steps_seen++;
    end
  end

  // Issue one step at a negedge in IDLE; cycle 1 is the first cycle after the
  // sampling edge. Returns the step_done cycle and the first idle cycle.
  task automatic run_step(input bit clr, input bit noise, output int done_cyc, output int idle_cyc);
    model_issue(clr);
    start = 1'b1;
    clear_ctx = clr;
    @(negedge clk);
    start = 1'b0;
    clear_ctx = 1'b0;
    done_cyc = -1;
    idle_cyc = -1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      if (step_done && done_cyc < 0) done_cyc = cyc;
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
      start = noise;
      clear_ctx = noise;
      @(negedge clk);
    end
    start = 1'b0;
    clear_ctx = 1'b0;
    if (idle_cyc < 0) check("step_timeout", 1, 0);
  endtask

  initial begin
    int dc, ic;
    int w;
    rst_n = 1'b0;
    start = 1'b0;
    clear_ctx = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'(outs), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Minimal-latency step
    run_step(1'b0, 1'b0, dc, ic);
    check("step_done_cycle", dc, 4 + 9 * NH);
    check("first_idle_cycle", ic, 5 + 9 * NH);

    // Random latencies and backpressure, wrapping the ring
    fixed_lat = 1'b0;
    ready_mode = 1;
    repeat (9) run_step(1'b0, 1'b0, dc, ic);

    // Five-cycle stall on head 0 with stray qk_done pulses during OUT
    fixed_lat = 1'b1;
    ready_mode = 2;
    stall_left = 5;
    spur_en = 1'b1;
    run_step(1'b0, 1'b0, dc, ic);
    check("stall_done_cycle", dc, 9 + 9 * NH);
    check("stall_idle_cycle", ic, 10 + 9 * NH);
    spur_en = 1'b0;

    // Context clear in IDLE, then ignored start/clear while busy
    fixed_lat = 1'b0;
    ready_mode = 1;
    repeat (3) run_step(1'b0, 1'b0, dc, ic);
    clear_ctx = 1'b1;
    @(negedge clk);
    clear_ctx = 1'b0;
    n_since_clear = 0;
    run_step(1'b0, 1'b0, dc, ic);
    run_step(1'b0, 1'b1, dc, ic);
    repeat (4) @(negedge clk);
    check("no_extra_step", int'(busy), 0);
    run_step(1'b0, 1'b0, dc, ic);

    // Clear together with start
    run_step(1'b1, 1'b0, dc, ic);

    // Asynchronous reset during QK of head 1
    fixed_lat = 1'b1;
    ready_mode = 0;
    model_issue(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (w = 0; w < 200 && !(qk_start && head_idx == 1'b1); w++) @(negedge clk);
    check("reach_head1_qk", int'(qk_start && head_idx == 1'b1), 1);
    #2 rst_n = 1'b0;
    #1 check("abort_outputs", int'(outs), 0);
    exp_wr.delete();
    exp_out.delete();
    exp_steps--;
    n_since_clear = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_step(1'b0, 1'b0, dc, ic);
    check("post_reset_done_cycle", dc, 4 + 9 * NH);

    repeat (3) @(negedge clk);
    check("steps_completed", steps_seen, exp_steps);
    check("writes_left", exp_wr.size(), 0);
    check("results_left", exp_out.size(), 0);
    check("err_low", int'(err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
